// File: rtl/plot_arbiter_if.sv
// Pixel-write bus between three requesters and the plot arbiter.
// The master modport is the requester side, the slave modport is the arbiter side.
interface plot_arbiter_if;
  logic [2:0]  req;
  logic [2:0]  lock;
  logic [23:0] req_x;
  logic [20:0] req_y;
  logic [8:0]  req_colour;
  logic        frame_start;
  logic [2:0]  gnt;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot;
  logic [7:0]  drop_count;

  modport master (
    output req, lock, req_x, req_y, req_colour, frame_start,
    input  gnt, x, y, colour, plot, drop_count
  );

  modport slave (
    input  req, lock, req_x, req_y, req_colour, frame_start,
    output gnt, x, y, colour, plot, drop_count
  );
endinterface

// File: rtl/plot_arbiter.sv
// Three-way round-robin pixel arbiter with burst lock, clipping and a per-frame
// drop counter; the winning pixel is registered one cycle later for the VGA adapter.
module plot_arbiter #(
  parameter int XMAX = 160,
  parameter int YMAX = 120
) (
  input  logic             clk,
  input  logic             reset,
  plot_arbiter_if.slave    bus
);

  typedef enum logic [0:0] {ARB = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [8:0] XLIM = 9'(XMAX);
  localparam logic [7:0] YLIM = 8'(YMAX);

  state_t      r_state;
  logic [1:0]  r_ptr;
  logic [1:0]  r_owner;
  logic [7:0]  r_x;
  logic [6:0]  r_y;
  logic [2:0]  r_colour;
  logic        r_plot;
  logic [7:0]  r_drop;

  logic [2:0]  w_gnt;
  logic [1:0]  w_idx;
  logic        w_valid;
  logic [2:0]  w_cand;
  logic [7:0]  w_px;
  logic [6:0]  w_py;
  logic [2:0]  w_pc;
  logic        w_in_range;

  function automatic logic [1:0] inc_mod3(input logic [1:0] v);
    case (v)
      2'd0:    inc_mod3 = 2'd1;
      2'd1:    inc_mod3 = 2'd2;
      default: inc_mod3 = 2'd0;
    endcase
  endfunction

  // Grant selection; the descending search lets the requester nearest ptr win.
  always_comb begin
    w_gnt   = 3'b000;
    w_idx   = 2'd0;
    w_valid = 1'b0;
    w_cand  = 3'd0;
    if (reset) begin
      w_valid = 1'b0;
    end else begin
      case (r_state)
        ARB: begin
          for (int k = 2; k >= 0; k--) begin
            w_cand = {1'b0, r_ptr} + 3'(k);
            if (w_cand >= 3'd3) w_cand = w_cand - 3'd3;
            else w_cand = w_cand;
            if (bus.req[w_cand[1:0]]) begin
              w_idx   = w_cand[1:0];
              w_valid = 1'b1;
            end else begin
              w_valid = w_valid;
            end
          end
        end
        LOCKED: begin
          w_idx   = r_owner;
          w_valid = bus.req[r_owner];
        end
        default: begin
          w_valid = 1'b0;
        end
      endcase
      if (w_valid) w_gnt = 3'b001 << w_idx;
      else w_gnt = 3'b000;
    end
  end

  assign w_px       = bus.req_x[8*w_idx +: 8];
  assign w_py       = bus.req_y[7*w_idx +: 7];
  assign w_pc       = bus.req_colour[3*w_idx +: 3];
  assign w_in_range = ({1'b0, w_px} < XLIM) && ({1'b0, w_py} < YLIM);

  // Arbitration state, output pixel register and drop counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ARB;
      r_ptr    <= 2'd0;
      r_owner  <= 2'd0;
      r_x      <= 8'd0;
      r_y      <= 7'd0;
      r_colour <= 3'd0;
      r_plot   <= 1'b0;
      r_drop   <= 8'd0;
    end else begin
      r_plot <= 1'b0;
      if (w_valid) begin
        r_x      <= w_px;
        r_y      <= w_py;
        r_colour <= w_pc;
        r_plot   <= w_in_range;
        if (!w_in_range && r_drop != 8'd255) r_drop <= r_drop + 8'd1;
      end
      case (r_state)
        ARB: begin
          if (w_valid) begin
            r_ptr <= inc_mod3(w_idx);
            if (bus.lock[w_idx]) begin
              r_state <= LOCKED;
              r_owner <= w_idx;
            end
          end
        end
        LOCKED: begin
          if (!bus.req[r_owner] || !bus.lock[r_owner]) begin
            r_state <= ARB;
            r_ptr   <= inc_mod3(r_owner);
          end
        end
        default: r_state <= ARB;
      endcase
      // Frame boundary wins over the pointer and counter updates above.
      if (bus.frame_start) begin
        r_ptr  <= 2'd0;
        r_drop <= 8'd0;
      end
    end
  end

  assign bus.gnt        = w_gnt;
  assign bus.x          = r_x;
  assign bus.y          = r_y;
  assign bus.colour     = r_colour;
  assign bus.plot       = r_plot;
  assign bus.drop_count = r_drop;

endmodule

// File: tb/tb_plot_arbiter.sv
// Directed bench for plot_arbiter: round robin, burst lock, clipping,
// drop saturation with frame_start, and reset during a locked burst.
module tb_plot_arbiter;
  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  plot_arbiter_if bus ();

  plot_arbiter #(.XMAX(160), .YMAX(120)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.req         = 3'b000;
    bus.lock        = 3'b000;
    bus.req_x       = 24'd0;
    bus.req_y       = 21'd0;
    bus.req_colour  = 9'd0;
    bus.frame_start = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset    = 1'b1;
    bus.req  = 3'b111;
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.gnt !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_gnt: got %b want 000", bus.gnt);
    end
    @(posedge clk);
    #1;
    reset   = 1'b0;
    bus.req = 3'b000;
    n_tests++;
    if ({bus.x, bus.y, bus.colour, bus.plot, bus.drop_count} !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: x=%0d y=%0d c=%0d plot=%b drop=%0d want all 0",
               bus.x, bus.y, bus.colour, bus.plot, bus.drop_count);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_gnt;
    logic [7:0] exp_x;
    do_reset();
    bus.req        = 3'b111;
    bus.req_x      = {8'd12, 8'd11, 8'd10};
    bus.req_y      = {7'd22, 7'd21, 7'd20};
    bus.req_colour = {3'd3, 3'd2, 3'd1};
    for (int i = 0; i < 6; i++) begin
      exp_gnt = 3'b001 << (i % 3);
      exp_x   = 8'(10 + (i % 3));
      #1;
      n_tests++;
      if (bus.gnt !== exp_gnt) begin
        n_fail++;
        $display("FAIL rr_gnt[%0d]: got %b want %b", i, bus.gnt, exp_gnt);
      end
      @(posedge clk);
      #1;
      n_tests++;
      if (bus.plot !== 1'b1 || bus.x !== exp_x || bus.y !== 7'(10 + exp_x)
          || bus.colour !== 3'(exp_x - 8'd9)) begin
        n_fail++;
        $display("FAIL rr_pixel[%0d]: plot=%b x=%0d y=%0d c=%0d want plot=1 x=%0d y=%0d c=%0d",
                 i, bus.plot, bus.x, bus.y, bus.colour, exp_x, 10 + exp_x, exp_x - 9);
      end
    end
    clear_inputs();
  endtask

  task automatic test_lock();
    do_reset();
    bus.req  = 3'b111;
    bus.lock = 3'b001;
    for (int i = 0; i < 10; i++) begin
      if (i == 9) bus.lock = 3'b000;
      #1;
      n_tests++;
      if (bus.gnt !== 3'b001) begin
        n_fail++;
        $display("FAIL lock_gnt[%0d]: got %b want 001", i, bus.gnt);
      end
      @(posedge clk);
      #1;
    end
    bus.req = 3'b110;
    #1;
    n_tests++;
    if (bus.gnt !== 3'b010) begin
      n_fail++;
      $display("FAIL lock_release_gnt: got %b want 010", bus.gnt);
    end
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic test_clip();
    logic [7:0] xs [3];
    logic [6:0] ys [3];
    logic       exp_plot [3];
    xs = '{8'd160, 8'd3, 8'd159};
    ys = '{7'd5, 7'd120, 7'd119};
    exp_plot = '{1'b0, 1'b0, 1'b1};
    do_reset();
    bus.req = 3'b010;
    for (int i = 0; i < 3; i++) begin
      bus.req_x = {8'd0, xs[i], 8'd0};
      bus.req_y = {7'd0, ys[i], 7'd0};
      #1;
      n_tests++;
      if (bus.gnt !== 3'b010) begin
        n_fail++;
        $display("FAIL clip_gnt[%0d]: got %b want 010", i, bus.gnt);
      end
      @(posedge clk);
      #1;
      n_tests++;
      if (bus.plot !== exp_plot[i]) begin
        n_fail++;
        $display("FAIL clip_plot[%0d]: got %b want %b", i, bus.plot, exp_plot[i]);
      end
    end
    n_tests++;
    if (bus.drop_count !== 8'd2 || bus.x !== 8'd159 || bus.y !== 7'd119) begin
      n_fail++;
      $display("FAIL clip_final: drop=%0d x=%0d y=%0d want drop=2 x=159 y=119",
               bus.drop_count, bus.x, bus.y);
    end
    bus.req = 3'b000;
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.plot !== 1'b0 || bus.x !== 8'd159 || bus.y !== 7'd119) begin
      n_fail++;
      $display("FAIL idle_hold: plot=%b x=%0d y=%0d want plot=0 x=159 y=119",
               bus.plot, bus.x, bus.y);
    end
    clear_inputs();
  endtask

  task automatic test_saturate();
    do_reset();
    bus.req   = 3'b001;
    bus.req_x = {16'd0, 8'd200};
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (i == 253) begin
        n_tests++;
        if (bus.drop_count !== 8'd254) begin
          n_fail++;
          $display("FAIL drop_254: got %0d want 254", bus.drop_count);
        end
      end
    end
    n_tests++;
    if (bus.drop_count !== 8'd255 || bus.plot !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_sat: drop=%0d plot=%b want drop=255 plot=0", bus.drop_count, bus.plot);
    end
    bus.req         = 3'b000;
    bus.frame_start = 1'b1;
    @(posedge clk);
    #1;
    bus.frame_start = 1'b0;
    n_tests++;
    if (bus.drop_count !== 8'd0) begin
      n_fail++;
      $display("FAIL frame_clear: got %0d want 0", bus.drop_count);
    end
    // Out-of-range grant in the frame_start cycle: grant happens, count stays 0.
    bus.req         = 3'b001;
    bus.frame_start = 1'b1;
    #1;
    n_tests++;
    if (bus.gnt !== 3'b001) begin
      n_fail++;
      $display("FAIL frame_same_gnt: got %b want 001", bus.gnt);
    end
    @(posedge clk);
    #1;
    bus.frame_start = 1'b0;
    n_tests++;
    if (bus.drop_count !== 8'd0) begin
      n_fail++;
      $display("FAIL frame_override: got %0d want 0", bus.drop_count);
    end
    bus.req = 3'b111;
    #1;
    n_tests++;
    if (bus.gnt !== 3'b001) begin
      n_fail++;
      $display("FAIL frame_ptr: got %b want 001", bus.gnt);
    end
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic test_reset_locked();
    do_reset();
    bus.req        = 3'b001;
    bus.lock       = 3'b001;
    bus.req_x      = {8'd0, 8'd30, 8'd5};
    bus.req_y      = {7'd0, 7'd40, 7'd6};
    bus.req_colour = {3'd0, 3'd4, 3'd7};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
    end
    n_tests++;
    if (bus.plot !== 1'b1 || bus.x !== 8'd5) begin
      n_fail++;
      $display("FAIL burst_pixel: plot=%b x=%0d want plot=1 x=5", bus.plot, bus.x);
    end
    reset = 1'b1;
    #1;
    n_tests++;
    if (bus.gnt !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_locked_gnt: got %b want 000", bus.gnt);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    n_tests++;
    if ({bus.x, bus.y, bus.colour, bus.plot, bus.drop_count} !== 27'd0) begin
      n_fail++;
      $display("FAIL rst_locked_out: x=%0d y=%0d c=%0d plot=%b drop=%0d want all 0",
               bus.x, bus.y, bus.colour, bus.plot, bus.drop_count);
    end
    bus.req  = 3'b010;
    bus.lock = 3'b000;
    #1;
    n_tests++;
    if (bus.gnt !== 3'b010) begin
      n_fail++;
      $display("FAIL rst_locked_arb: got %b want 010", bus.gnt);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.plot !== 1'b1 || bus.x !== 8'd30 || bus.colour !== 3'd4) begin
      n_fail++;
      $display("FAIL rst_locked_pixel: plot=%b x=%0d c=%0d want plot=1 x=30 c=4",
               bus.plot, bus.x, bus.colour);
    end
    clear_inputs();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    clear_inputs();
    #1;
    test_reset();
    test_round_robin();
    test_lock();
    test_clip();
    test_saturate();
    test_reset_locked();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
